// File: rtl/lbist_session_ctrl.sv
// lbist_session_ctrl: golden + N_FAULTS fault-injection LBIST session sequencer; LBIST_TIMEOUT_EN adds the RUN watchdog.
module lbist_session_ctrl #(
  parameter int ERR_BITS   = 8,
  parameter int N_CH       = 4,
  parameter int N_FAULTS   = 6,
  parameter int FAULT_BITS = 3,
  parameter int TO_BITS    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_CH-1:0]       ch_mask,
  input  logic                  TPG_E,
  input  logic [N_CH-1:0]       ORA_R,
  output logic                  SES_R,
  output logic                  TPG_R,
  output logic                  FIC_I,
  output logic [FAULT_BITS-1:0] FIC_IDX,
  output logic [ERR_BITS-1:0]   ERR,
  output logic [ERR_BITS-1:0]   DET,
  output logic                  GOLD_F,
  output logic                  TO,
  output logic                  busy,
  output logic                  done
);
  localparam logic [2:0] IDLE = 3'd0, INIT = 3'd1, RUN = 3'd2, EVAL = 3'd3, DONE = 3'd4;
  localparam logic [ERR_BITS-1:0] SAT = '1;
  localparam logic [FAULT_BITS-1:0] LAST = FAULT_BITS'(N_FAULTS);
  logic [2:0] state;
  logic [N_CH-1:0] mask;
  logic sticky;
  logic hit;
  logic fin;
  logic expire;
  logic launch;
  assign hit    = |(ORA_R & mask);
  assign fin    = FIC_IDX >= LAST;
  assign launch = (state == IDLE || state == DONE) && start;
`ifdef LBIST_TIMEOUT_EN
  // Abort on the (2^TO_BITS-1)th RUN cycle without TPG_E; wd holds completed RUN cycles.
  localparam logic [TO_BITS-1:0] WD_LAST = {{(TO_BITS-1){1'b1}}, 1'b0};
  logic [TO_BITS-1:0] wd;
  logic to_q;
  assign expire = wd == WD_LAST;
  assign TO     = to_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      wd   <= '0;
      to_q <= 1'b0;
    end else begin
      wd   <= state == INIT ? '0 : state == RUN ? wd + 1'b1 : wd;
      to_q <= launch ? 1'b0 : (state == RUN && !TPG_E && expire) ? 1'b1 : to_q;
    end
  end
`else
  assign expire = 1'b0;
  assign TO     = 1'b0;
`endif
  assign SES_R = state == INIT;
  assign TPG_R = state == INIT;
  assign FIC_I = state == EVAL && !fin;
  assign busy  = state == INIT || state == RUN || state == EVAL;
  assign done  = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mask    <= '1;
      sticky  <= 1'b0;
      FIC_IDX <= '0;
      ERR     <= '0;
      DET     <= '0;
      GOLD_F  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          mask    <= ch_mask;
          FIC_IDX <= '0;
          ERR     <= '0;
          DET     <= '0;
          GOLD_F  <= 1'b0;
          state   <= INIT;
        end
        INIT: begin
          sticky <= 1'b0;
          state  <= RUN;
        end
        RUN: begin
          sticky <= sticky | hit;
          if (TPG_E) state <= EVAL;
          else if (expire) state <= DONE;
        end
        EVAL: begin
          if (FIC_IDX == '0) GOLD_F <= sticky;
          else if (sticky) DET <= DET == SAT ? DET : DET + 1'b1;
          else ERR <= ERR == SAT ? ERR : ERR + 1'b1;
          if (fin) state <= DONE;
          else begin
            FIC_IDX <= FIC_IDX + 1'b1;
            state   <= INIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lbist_session_ctrl.sv
// tb_lbist_session_ctrl: directed bench for lbist_session_ctrl (default, ERR_BITS=2 and TO_BITS=4 instances).
module tb_lbist_session_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [2:0] start;
  logic [3:0] ch_mask, ORA_R;
  logic TPG_E;
  logic ses0, tpg0, fic0, gold0, to0, busy0, done0;
  logic [2:0] idx0;
  logic [7:0] err0, det0;
  logic ses1, tpg1, fic1, gold1, to1, busy1, done1;
  logic [2:0] idx1;
  logic [1:0] err1, det1;
  logic ses2, tpg2, fic2, gold2, to2, busy2, done2;
  logic [2:0] idx2;
  logic [7:0] err2, det2;
  lbist_session_ctrl u0 (.clk(clk), .rst(rst), .start(start[0]), .ch_mask(ch_mask), .TPG_E(TPG_E), .ORA_R(ORA_R),
    .SES_R(ses0), .TPG_R(tpg0), .FIC_I(fic0), .FIC_IDX(idx0), .ERR(err0), .DET(det0), .GOLD_F(gold0), .TO(to0),
    .busy(busy0), .done(done0));
  lbist_session_ctrl #(.ERR_BITS(2)) u1 (.clk(clk), .rst(rst), .start(start[1]), .ch_mask(ch_mask), .TPG_E(TPG_E),
    .ORA_R(ORA_R), .SES_R(ses1), .TPG_R(tpg1), .FIC_I(fic1), .FIC_IDX(idx1), .ERR(err1), .DET(det1), .GOLD_F(gold1),
    .TO(to1), .busy(busy1), .done(done1));
  lbist_session_ctrl #(.TO_BITS(4)) u2 (.clk(clk), .rst(rst), .start(start[2]), .ch_mask(ch_mask), .TPG_E(TPG_E),
    .ORA_R(ORA_R), .SES_R(ses2), .TPG_R(tpg2), .FIC_I(fic2), .FIC_IDX(idx2), .ERR(err2), .DET(det2), .GOLD_F(gold2),
    .TO(to2), .busy(busy2), .done(done2));
  int total = 0, bad = 0;
  int fic_n0 = 0, fic_n1 = 0, fic_n2 = 0;
  int sel;
  logic ses_s, tpg_s, done_s, busy_s, gold_s, to_s;
  logic [2:0] idx_s;
  logic [7:0] err_s, det_s;
  int fic_s;
  always @(posedge clk) begin
    if (fic0) fic_n0++;
    if (fic1) fic_n1++;
    if (fic2) fic_n2++;
  end
  always_comb begin
    ses_s  = sel == 0 ? ses0 : sel == 1 ? ses1 : ses2;
    tpg_s  = sel == 0 ? tpg0 : sel == 1 ? tpg1 : tpg2;
    done_s = sel == 0 ? done0 : sel == 1 ? done1 : done2;
    busy_s = sel == 0 ? busy0 : sel == 1 ? busy1 : busy2;
    gold_s = sel == 0 ? gold0 : sel == 1 ? gold1 : gold2;
    to_s   = sel == 0 ? to0 : sel == 1 ? to1 : to2;
    idx_s  = sel == 0 ? idx0 : sel == 1 ? idx1 : idx2;
    err_s  = sel == 0 ? err0 : sel == 1 ? {6'b0, err1} : err2;
    det_s  = sel == 0 ? det0 : sel == 1 ? {6'b0, det1} : det2;
    fic_s  = sel == 0 ? fic_n0 : sel == 1 ? fic_n1 : fic_n2;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic start_run(input int d, input logic [3:0] m);
    sel = d;
    ch_mask = m;
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    ch_mask = 4'b1010;
  endtask
  task automatic session(input int len, input int pos, input logic [3:0] ora);
    check("ses_r", ses_s, 1);
    check("tpg_r", tpg_s, 1);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      ORA_R = i == pos ? ora : 4'h0;
      TPG_E = i == len - 1;
    end
    @(negedge clk);
    ORA_R = 4'h0;
    TPG_E = 1'b0;
    @(negedge clk);
  endtask
  task automatic run_all(input int d, input logic [3:0] m, input logic [6:0] hits, input logic [3:0] ora,
                         input bit at_end, output int pulses);
    int base;
    start_run(d, m);
    base = fic_s;
    check("init_idx", idx_s, 0);
    for (int s = 0; s < 7; s++) begin
      int len;
      len = 1 + s % 3;
      session(len, at_end ? len - 1 : 0, hits[s] ? ora : 4'h0);
    end
    pulses = fic_s - base;
    check("done", done_s, 1);
    check("idx_end", idx_s, 6);
  endtask
  initial begin
    int p;
    int base;
    rst = 1'b1;
    start = '0;
    ch_mask = 4'hF;
    ORA_R = '0;
    TPG_E = 1'b0;
    sel = 0;
    repeat (3) @(negedge clk);
    check("rst_outs", {ses0, tpg0, fic0, busy0, done0, gold0, to0, idx0, err0, det0}, 0);
    rst = 1'b0;
    @(negedge clk);
    run_all(0, 4'hF, 7'b0101010, 4'b0100, 1'b0, p);
    check("a_det", det_s, 3);
    check("a_err", err_s, 3);
    check("a_gold", gold_s, 0);
    check("a_fic", p, 6);
    TPG_E = 1'b1;
    ORA_R = 4'hF;
    repeat (3) @(negedge clk);
    TPG_E = 1'b0;
    ORA_R = 4'h0;
    check("hold_done", done_s, 1);
    check("hold_busy", busy_s, 0);
    check("hold_cnt", {det_s, err_s}, 16'h0303);
    run_all(0, 4'b0001, 7'b1111110, 4'b1000, 1'b0, p);
    check("b_err", err_s, 6);
    check("b_det", det_s, 0);
    run_all(0, 4'hF, 7'b0000001, 4'b0100, 1'b1, p);
    check("c_gold", gold_s, 1);
    check("c_err", err_s, 6);
    check("c_det", det_s, 0);
    run_all(0, 4'h0, 7'h7F, 4'hF, 1'b0, p);
    check("z_err", err_s, 6);
    check("z_det", det_s, 0);
    check("z_gold", gold_s, 0);
    start_run(0, 4'hF);
    base = fic_s;
    session(2, 0, 4'h0);
    session(2, 0, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_outs", {ses0, tpg0, fic0, busy0, done0, gold0, to0, idx0, err0, det0}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_fic", fic_s - base, 2);
    run_all(0, 4'hF, 7'h00, 4'h0, 1'b0, p);
    check("r_err", err_s, 6);
    check("r_fic", p, 6);
    check("to_low", to0, 0);
    run_all(1, 4'hF, 7'h00, 4'h0, 1'b0, p);
    check("sat_err", err_s, 3);
    check("sat_det", det_s, 0);
    check("sat_fic", p, 6);
`ifdef LBIST_TIMEOUT_EN
    start_run(2, 4'hF);
    base = fic_s;
    session(2, 0, 4'h0);
    repeat (15) @(negedge clk);
    check("wd_busy", busy_s, 1);
    check("wd_to_early", to_s, 0);
    @(negedge clk);
    check("wd_to", to_s, 1);
    check("wd_done", done_s, 1);
    check("wd_cnt", {det_s, err_s}, 0);
    check("wd_idx", idx_s, 1);
    check("wd_fic", fic_s - base, 1);
`else
    start_run(2, 4'hF);
    session(2, 0, 4'h0);
    repeat (20) @(negedge clk);
    check("nowd_busy", busy_s, 1);
    check("nowd_to", to_s, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
